// File: rtl/rv32f_decode_pkg.sv
// Shared encodings, op/rounding-mode enums and the decoded micro-op struct
// for the RV32F decode stage.
package rv32f_decode_pkg;

    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_FMADD    = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD   = 7'b1001111;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

    localparam logic [6:0] F7_FADD     = 7'b0000000;
    localparam logic [6:0] F7_FSUB     = 7'b0000100;
    localparam logic [6:0] F7_FMUL     = 7'b0001000;
    localparam logic [6:0] F7_FDIV     = 7'b0001100;
    localparam logic [6:0] F7_FSQRT    = 7'b0101100;
    localparam logic [6:0] F7_FSGNJ    = 7'b0010000;
    localparam logic [6:0] F7_FMINMAX  = 7'b0010100;
    localparam logic [6:0] F7_FCVT_W_S = 7'b1100000;
    localparam logic [6:0] F7_FMV_X_W  = 7'b1110000;
    localparam logic [6:0] F7_FCMP     = 7'b1010000;
    localparam logic [6:0] F7_FCVT_S_W = 7'b1101000;
    localparam logic [6:0] F7_FMV_W_X  = 7'b1111000;

    localparam logic [2:0] F3_WIDTH_W = 3'b010;
    localparam logic [4:0] F5_W       = 5'b00000;
    localparam logic [4:0] F5_WU      = 5'b00001;

    typedef enum logic [4:0] {
        FLW       = 5'd0,  FSW       = 5'd1,  FMADD     = 5'd2,  FMSUB     = 5'd3,
        FNMSUB    = 5'd4,  FNMADD    = 5'd5,  FADD      = 5'd6,  FSUB      = 5'd7,
        FMUL      = 5'd8,  FDIV      = 5'd9,  FSQRT     = 5'd10, FSGNJ     = 5'd11,
        FSGNJN    = 5'd12, FSGNJX    = 5'd13, FMIN      = 5'd14, FMAX      = 5'd15,
        FCVT_W_S  = 5'd16, FCVT_WU_S = 5'd17, FMV_X_W   = 5'd18, FCLASS    = 5'd19,
        FEQ       = 5'd20, FLT       = 5'd21, FLE       = 5'd22, FCVT_S_W  = 5'd23,
        FCVT_S_WU = 5'd24, FMV_W_X   = 5'd25, NONE      = 5'd26
    } rv32f_op_t;

    typedef enum logic [2:0] {
        RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3,
        RMM = 3'd4, RM_RSV5 = 3'd5, RM_RSV6 = 3'd6, DYN = 3'd7
    } rv32f_rm_t;

    typedef struct packed {
        rv32f_op_t   op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rs3;
        rv32f_rm_t   rm;
        logic [31:0] imm;
        logic        rs1_int;
        logic        rd_int;
        logic        uses_rs2;
        logic        uses_rs3;
        logic        illegal;
    } rv32f_decoded_t;

    localparam rv32f_decoded_t DEC_RESET = '{
        op: NONE, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, rs3: 5'd0, rm: RNE,
        imm: 32'd0, rs1_int: 1'b0, rd_int: 1'b0, uses_rs2: 1'b0,
        uses_rs3: 1'b0, illegal: 1'b0
    };

    // Returns {bad, rm}: reserved static modes, and dynamic mode with a reserved frm, are bad.
    function automatic logic [3:0] rm_resolve(input logic [2:0] f3, input logic [2:0] frm);
        logic [3:0] res;
        case (f3)
            3'b101, 3'b110: res = {1'b1, 3'b000};
            3'b111: begin
                if (frm >= 3'b101) begin
                    res = {1'b1, 3'b000};
                end else begin
                    res = {1'b0, frm};
                end
            end
            default: res = {1'b0, f3};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rv32f_decode_logic.sv
// Combinational RV32F instruction decoder: raw word plus fcsr.frm to a
// decoded micro-op. Illegal words keep their register fields, nothing else.
module rv32f_decode_logic
    import rv32f_decode_pkg::*;
(
    input  logic [31:0]    inst,
    input  logic [2:0]     frm,
    output rv32f_decoded_t dec
);

    logic [6:0]  opcode_s;
    logic [6:0]  funct7_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rs2_s;
    rv32f_op_t   op_s;
    logic        legal_s;
    logic        is_rm_s;
    logic [31:0] imm_s;
    logic        rs1_int_s;
    logic        rd_int_s;
    logic        uses_rs2_s;
    logic        uses_rs3_s;
    logic [3:0]  rm_res_s;

    assign opcode_s = inst[6:0];
    assign funct7_s = inst[31:25];
    assign funct3_s = inst[14:12];
    assign rs2_s    = inst[24:20];
    assign rm_res_s = rm_resolve(funct3_s, frm);

    // Classify the word; operand flags set here are masked later if the word is illegal.
    always_comb begin
        op_s       = NONE;
        legal_s    = 1'b0;
        is_rm_s    = 1'b0;
        imm_s      = 32'd0;
        rs1_int_s  = 1'b0;
        rd_int_s   = 1'b0;
        uses_rs2_s = 1'b0;
        uses_rs3_s = 1'b0;
        case (opcode_s)
            OPC_LOAD_FP: begin
                op_s      = FLW;
                legal_s   = (funct3_s == F3_WIDTH_W);
                imm_s     = {{20{inst[31]}}, inst[31:20]};
                rs1_int_s = 1'b1;
            end
            OPC_STORE_FP: begin
                op_s       = FSW;
                legal_s    = (funct3_s == F3_WIDTH_W);
                imm_s      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                rs1_int_s  = 1'b1;
                uses_rs2_s = 1'b1;
            end
            OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: begin
                legal_s    = (inst[26:25] == 2'b00);
                is_rm_s    = 1'b1;
                uses_rs2_s = 1'b1;
                uses_rs3_s = 1'b1;
                case (opcode_s)
                    OPC_FMADD:  op_s = FMADD;
                    OPC_FMSUB:  op_s = FMSUB;
                    OPC_FNMSUB: op_s = FNMSUB;
                    default:    op_s = FNMADD;
                endcase
            end
            OPC_OP_FP: begin
                case (funct7_s)
                    F7_FADD, F7_FSUB, F7_FMUL, F7_FDIV: begin
                        legal_s    = 1'b1;
                        is_rm_s    = 1'b1;
                        uses_rs2_s = 1'b1;
                        case (funct7_s)
                            F7_FADD: op_s = FADD;
                            F7_FSUB: op_s = FSUB;
                            F7_FMUL: op_s = FMUL;
                            default: op_s = FDIV;
                        endcase
                    end
                    F7_FSQRT: begin
                        op_s    = FSQRT;
                        legal_s = (rs2_s == 5'd0);
                        is_rm_s = 1'b1;
                    end
                    F7_FSGNJ: begin
                        uses_rs2_s = 1'b1;
                        case (funct3_s)
                            3'b000:  begin op_s = FSGNJ;  legal_s = 1'b1; end
                            3'b001:  begin op_s = FSGNJN; legal_s = 1'b1; end
                            3'b010:  begin op_s = FSGNJX; legal_s = 1'b1; end
                            default: legal_s = 1'b0;
                        endcase
                    end
                    F7_FMINMAX: begin
                        uses_rs2_s = 1'b1;
                        case (funct3_s)
                            3'b000:  begin op_s = FMIN; legal_s = 1'b1; end
                            3'b001:  begin op_s = FMAX; legal_s = 1'b1; end
                            default: legal_s = 1'b0;
                        endcase
                    end
                    F7_FCVT_W_S: begin
                        is_rm_s  = 1'b1;
                        rd_int_s = 1'b1;
                        case (rs2_s)
                            F5_W:    begin op_s = FCVT_W_S;  legal_s = 1'b1; end
                            F5_WU:   begin op_s = FCVT_WU_S; legal_s = 1'b1; end
                            default: legal_s = 1'b0;
                        endcase
                    end
                    F7_FMV_X_W: begin
                        rd_int_s = 1'b1;
                        case (funct3_s)
                            3'b000:  begin op_s = FMV_X_W; legal_s = (rs2_s == 5'd0); end
                            3'b001:  begin op_s = FCLASS;  legal_s = (rs2_s == 5'd0); end
                            default: legal_s = 1'b0;
                        endcase
                    end
                    F7_FCMP: begin
                        rd_int_s   = 1'b1;
                        uses_rs2_s = 1'b1;
                        case (funct3_s)
                            3'b000:  begin op_s = FLE; legal_s = 1'b1; end
                            3'b001:  begin op_s = FLT; legal_s = 1'b1; end
                            3'b010:  begin op_s = FEQ; legal_s = 1'b1; end
                            default: legal_s = 1'b0;
                        endcase
                    end
                    F7_FCVT_S_W: begin
                        is_rm_s   = 1'b1;
                        rs1_int_s = 1'b1;
                        case (rs2_s)
                            F5_W:    begin op_s = FCVT_S_W;  legal_s = 1'b1; end
                            F5_WU:   begin op_s = FCVT_S_WU; legal_s = 1'b1; end
                            default: legal_s = 1'b0;
                        endcase
                    end
                    F7_FMV_W_X: begin
                        op_s      = FMV_W_X;
                        rs1_int_s = 1'b1;
                        legal_s   = (funct3_s == 3'b000) && (rs2_s == 5'd0);
                    end
                    default: legal_s = 1'b0;
                endcase
            end
            default: legal_s = 1'b0;
        endcase
    end

    // Assemble the micro-op; a bad rounding mode turns an otherwise legal word illegal.
    always_comb begin
        dec     = DEC_RESET;
        dec.rd  = inst[11:7];
        dec.rs1 = inst[19:15];
        dec.rs2 = inst[24:20];
        dec.rs3 = inst[31:27];
        if (legal_s && !(is_rm_s && rm_res_s[3])) begin
            dec.op       = op_s;
            dec.rm       = is_rm_s ? rv32f_rm_t'(rm_res_s[2:0]) : RNE;
            dec.imm      = imm_s;
            dec.rs1_int  = rs1_int_s;
            dec.rd_int   = rd_int_s;
            dec.uses_rs2 = uses_rs2_s;
            dec.uses_rs3 = uses_rs3_s;
            dec.illegal  = 1'b0;
        end else begin
            dec.op      = NONE;
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/rv32f_decode.sv
// Registered RV32F decode stage: decoder feeding a main register plus one
// skid entry, so in_ready is a flop and never depends on out_ready.
module rv32f_decode
    import rv32f_decode_pkg::*;
#(
    parameter int PC_WIDTH     = 32,
    parameter bit ILLEGAL_PASS = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic [2:0]          frm,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          out_op,
    output logic [4:0]          out_rd,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [4:0]          out_rs3,
    output logic [2:0]          out_rm,
    output logic [31:0]         out_imm,
    output logic                out_rs1_int,
    output logic                out_rd_int,
    output logic                out_uses_rs2,
    output logic                out_uses_rs3,
    output logic                out_illegal,
    output logic [PC_WIDTH-1:0] out_pc
);

    rv32f_decoded_t      dec_s;
    rv32f_decoded_t      main_r;
    rv32f_decoded_t      skid_r;
    logic [PC_WIDTH-1:0] main_pc_r;
    logic [PC_WIDTH-1:0] skid_pc_r;
    logic                main_vld_r;
    logic                skid_vld_r;
    logic                accept_s;
    logic                load_s;
    logic                advance_s;

    rv32f_decode_logic u_logic (
        .inst (in_inst),
        .frm  (frm),
        .dec  (dec_s)
    );

    assign accept_s  = in_valid && !skid_vld_r && !flush;
    assign load_s    = accept_s && (ILLEGAL_PASS || !dec_s.illegal);
    // Main register can take a new entry when empty or when it is leaving this cycle.
    assign advance_s = !main_vld_r || out_ready;

    // Valid bits of the two entries; skid refills main before any new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld_r <= 1'b0;
            skid_vld_r <= 1'b0;
        end else if (flush) begin
            main_vld_r <= 1'b0;
            skid_vld_r <= 1'b0;
        end else if (advance_s) begin
            if (skid_vld_r) begin
                main_vld_r <= 1'b1;
                skid_vld_r <= 1'b0;
            end else begin
                main_vld_r <= load_s;
            end
        end else if (load_s) begin
            skid_vld_r <= 1'b1;
        end
    end

    // Payload of the two entries, including the PC carried for exception reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_r    <= DEC_RESET;
            skid_r    <= DEC_RESET;
            main_pc_r <= '0;
            skid_pc_r <= '0;
        end else if (!flush) begin
            if (advance_s) begin
                if (skid_vld_r) begin
                    main_r    <= skid_r;
                    main_pc_r <= skid_pc_r;
                end else if (load_s) begin
                    main_r    <= dec_s;
                    main_pc_r <= in_pc;
                end
            end else if (load_s) begin
                skid_r    <= dec_s;
                skid_pc_r <= in_pc;
            end
        end
    end

    assign in_ready     = !skid_vld_r;
    assign out_valid    = main_vld_r;
    assign out_op       = main_r.op;
    assign out_rd       = main_r.rd;
    assign out_rs1      = main_r.rs1;
    assign out_rs2      = main_r.rs2;
    assign out_rs3      = main_r.rs3;
    assign out_rm       = main_r.rm;
    assign out_imm      = main_r.imm;
    assign out_rs1_int  = main_r.rs1_int;
    assign out_rd_int   = main_r.rd_int;
    assign out_uses_rs2 = main_r.uses_rs2;
    assign out_uses_rs3 = main_r.uses_rs3;
    assign out_illegal  = main_r.illegal;
    assign out_pc       = main_pc_r;

endmodule

// File: tb/tb_rv32f_decode.sv
// Scoreboard bench for rv32f_decode: directed words with hand-decoded
// expectations, checked in order by an independent output monitor.
module tb_rv32f_decode;
    import rv32f_decode_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [2:0]  frm;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_op, out_rd, out_rs1, out_rs2, out_rs3;
    logic [2:0]  out_rm;
    logic [31:0] out_imm;
    logic        out_rs1_int, out_rd_int, out_uses_rs2, out_uses_rs3, out_illegal;
    logic [31:0] out_pc;

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rs3;
        logic [2:0]  rm;
        logic [31:0] imm;
        logic [4:0]  flags;   // {rs1_int, rd_int, uses_rs2, uses_rs3, illegal}
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   stamps[$];
    int   cyc;
    int   checks;
    int   errors;

    rv32f_decode #(.PC_WIDTH(32), .ILLEGAL_PASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .frm(frm),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rs3(out_rs3), .out_rm(out_rm), .out_imm(out_imm),
        .out_rs1_int(out_rs1_int), .out_rd_int(out_rd_int),
        .out_uses_rs2(out_uses_rs2), .out_uses_rs3(out_uses_rs3),
        .out_illegal(out_illegal), .out_pc(out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output transfer pops and compares the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (rst_n && out_valid && out_ready) begin
            checks = checks + 1;
            got = {out_op, out_rd, out_rs1, out_rs2, out_rs3, out_rm, out_imm,
                   {out_rs1_int, out_rd_int, out_uses_rs2, out_uses_rs3, out_illegal}, out_pc};
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_output got=%h required no output", got);
            end else begin
                e = exp_q.pop_front();
                stamps.push_back(cyc);
                if (got !== e) begin
                    errors = errors + 1;
                    $display("FAIL out_word pc=%h got=%h required=%h", e.pc, got, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s got=%h required=%h", name, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rs3, input logic [2:0] rm,
                                input logic [31:0] imm, input logic [4:0] flags, input logic [31:0] pc);
        exp_t e;
        e = {op, rd, rs1, rs2, rs3, rm, imm, flags, pc};
        return e;
    endfunction

    task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [2:0] f);
        int n;
        in_inst  = i;
        in_pc    = p;
        frm      = f;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL send_timeout pc=%h in_ready=0 required 1", p);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain_timeout left=%0d required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  frm;
        exp_t        e;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int   n;
        cyc = 0; checks = 0; errors = 0;
        rst_n = 1'b0; flush = 1'b0; frm = 3'd0; in_valid = 1'b0;
        in_inst = 32'd0; in_pc = 32'd0; out_ready = 1'b1;

        #12;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_op_none", out_op, 26);
        chk("reset_fields", {out_rd, out_rm, out_imm, out_pc, out_illegal}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word into an empty stage must appear one cycle later.
        exp_q.push_back(mk(FADD, 5'd1, 5'd2, 5'd3, 5'd0, 3'd0, 32'd0, 5'b00100, 32'h1000));
        send(32'h003100D3, 32'h1000, 3'd0);
        chk("fadd_latency_valid", out_valid, 1);
        wait_drain();

        vecs.push_back('{32'hFFC52287, 3'd0, mk(FLW,      5'd5,  5'd10, 5'd28, 5'd31, 3'd0, 32'hFFFFFFFC, 5'b10000, 32'h1004)});
        vecs.push_back('{32'h103170D3, 3'd1, mk(FMUL,     5'd1,  5'd2,  5'd3,  5'd2,  3'd1, 32'd0,        5'b00100, 32'h1008)});
        vecs.push_back('{32'h103170D3, 3'd5, mk(NONE,     5'd1,  5'd2,  5'd3,  5'd2,  3'd0, 32'd0,        5'b00001, 32'h100C)});
        vecs.push_back('{32'h581100D3, 3'd0, mk(NONE,     5'd1,  5'd2,  5'd1,  5'd11, 3'd0, 32'd0,        5'b00001, 32'h1010)});
        vecs.push_back('{32'h580100D3, 3'd0, mk(FSQRT,    5'd1,  5'd2,  5'd0,  5'd11, 3'd0, 32'd0,        5'b00000, 32'h1014)});
        vecs.push_back('{32'hFE20AC27, 3'd0, mk(FSW,      5'd24, 5'd1,  5'd2,  5'd31, 3'd0, 32'hFFFFFFF8, 5'b10100, 32'h1018)});
        vecs.push_back('{32'h18208243, 3'd0, mk(FMADD,    5'd4,  5'd1,  5'd2,  5'd3,  3'd0, 32'd0,        5'b00110, 32'h101C)});
        vecs.push_back('{32'h1A208243, 3'd0, mk(NONE,     5'd4,  5'd1,  5'd2,  5'd3,  3'd0, 32'd0,        5'b00001, 32'h1020)});
        vecs.push_back('{32'hC00312D3, 3'd0, mk(FCVT_W_S, 5'd5,  5'd6,  5'd0,  5'd24, 3'd1, 32'd0,        5'b01000, 32'h1024)});
        vecs.push_back('{32'hA020A1D3, 3'd0, mk(FEQ,      5'd3,  5'd1,  5'd2,  5'd20, 3'd0, 32'd0,        5'b01100, 32'h1028)});
        vecs.push_back('{32'hF00483D3, 3'd0, mk(FMV_W_X,  5'd7,  5'd9,  5'd0,  5'd30, 3'd0, 32'd0,        5'b10000, 32'h102C)});
        vecs.push_back('{32'h00000013, 3'd0, mk(NONE,     5'd0,  5'd0,  5'd0,  5'd0,  3'd0, 32'd0,        5'b00001, 32'h1030)});
        vecs.push_back('{32'hFFC53287, 3'd0, mk(NONE,     5'd5,  5'd10, 5'd28, 5'd31, 3'd0, 32'd0,        5'b00001, 32'h1034)});
        foreach (vecs[k]) begin
            exp_q.push_back(vecs[k].e);
            send(vecs[k].inst, vecs[k].e.pc, vecs[k].frm);
        end
        wait_drain();

        // frm changing after acceptance must not alter the buffered rm.
        out_ready = 1'b0;
        exp_q.push_back(mk(FMUL, 5'd1, 5'd2, 5'd3, 5'd2, 3'd1, 32'd0, 5'b00100, 32'h1100));
        send(32'h103170D3, 32'h1100, 3'd1);
        frm = 3'd4;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

        // Stall with four words queued, then release and expect one output per cycle.
        out_ready = 1'b0;
        stamps.delete();
        exp_q.push_back(mk(FADD,  5'd1, 5'd2,  5'd3,  5'd0,  3'd0, 32'd0,        5'b00100, 32'h200));
        exp_q.push_back(mk(FLW,   5'd5, 5'd10, 5'd28, 5'd31, 3'd0, 32'hFFFFFFFC, 5'b10000, 32'h201));
        exp_q.push_back(mk(FEQ,   5'd3, 5'd1,  5'd2,  5'd20, 3'd0, 32'd0,        5'b01100, 32'h202));
        exp_q.push_back(mk(FSQRT, 5'd1, 5'd2,  5'd0,  5'd11, 3'd0, 32'd0,        5'b00000, 32'h203));
        fork
            begin
                send(32'h003100D3, 32'h200, 3'd0);
                send(32'hFFC52287, 32'h201, 3'd0);
                send(32'hA020A1D3, 32'h202, 3'd0);
                send(32'h580100D3, 32'h203, 3'd0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("skid_full_in_ready", in_ready, 0);
                chk("skid_full_out_valid", out_valid, 1);
                out_ready = 1'b1;
            end
        join
        wait_drain();
        n = stamps.size();
        chk("stream_count", n, 4);
        if (n >= 4) chk("stream_throughput", stamps[n-1] - stamps[n-4], 3);

        // Flush with both entries full and an input waiting.
        out_ready = 1'b0;
        send(32'h003100D3, 32'h300, 3'd0);
        send(32'hFFC52287, 32'h301, 3'd0);
        in_inst = 32'hA020A1D3; in_pc = 32'h302; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Flush on the same edge as an accepted input discards that input.
        out_ready = 1'b0;
        send(32'h003100D3, 32'h310, 3'd0);
        in_inst = 32'h580100D3; in_pc = 32'h311; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_discard_valid", out_valid, 0);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        exp_q.push_back(mk(FADD, 5'd1, 5'd2, 5'd3, 5'd0, 3'd0, 32'd0, 5'b00100, 32'h320));
        send(32'h003100D3, 32'h320, 3'd0);
        wait_drain();

        // Asynchronous reset mid-stream clears outputs without waiting for a clock.
        out_ready = 1'b0;
        send(32'hFFC52287, 32'h400, 3'd0);
        send(32'h003100D3, 32'h401, 3'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_op_none", out_op, 26);
        chk("rst_mid_fields", {out_rd, out_rs1, out_imm, out_pc, out_rs1_int}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
